// File: rtl/floppy_pkg.sv
// Shared types and defaults for the floppy disk-image fetch arbiter.
package floppy_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

  localparam int AW_DEF      = 22;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/floppy_arb_watchdog.sv
// WAIT-state watchdog for floppy_img_arbiter. Only built when
// FLOPPY_ARB_TIMEOUT_EN is defined; counts cycles while run is high and
// flags expiry in the TIMEOUT-th cycle so the arbiter aborts on that edge.
`ifdef FLOPPY_ARB_TIMEOUT_EN
module floppy_arb_watchdog
  import floppy_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk8,
  input  logic _reset,
  input  logic run,
  output logic expired
);

  logic [7:0] count;

  assign expired = run && (count == 8'(TIMEOUT - 1));

  // Count WAIT cycles; cleared whenever the arbiter is idle.
  always_ff @(posedge clk8 or negedge _reset) begin
    if (!_reset) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/floppy_img_arbiter.sv
// Round-robin arbiter sharing one disk-image read port between the internal
// (0) and external (1) floppy drives. One transaction at a time: IDLE picks a
// requester, WAIT holds the memory request until memReadAck.
// Optional WAIT watchdog: define FLOPPY_ARB_TIMEOUT_EN to abort stalled reads
// after TIMEOUT cycles with rdData = 8'hFF and a timeout pulse.
module floppy_img_arbiter
  import floppy_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic          clk8,
  input  logic          _reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          ack0,
  output logic          ack1,
  output logic [7:0]    rdData,
  output logic [AW-1:0] memReadAddr,
  output logic          memReadReq,
  input  logic          memReadAck,
  input  logic [7:0]    memReadData,
  output logic          grant,
  output logic          busy,
  output logic          timeout
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("floppy_img_arbiter: TIMEOUT must be in 1..255");
  end

  arb_state_t state, state_n;
  logic       tie_pick;   // requester that wins the next tie
  logic       take0, take1;
  logic       start, sel, done, abort;
  logic       expired;

  assign memReadReq = (state == ST_WAIT);
  assign busy       = (state == ST_WAIT);

  // A level request is still visible in its own ack cycle; masking it there
  // stops a just-served requester from launching a duplicate fetch.
  assign take0 = req0 & ~ack0;
  assign take1 = req1 & ~ack1;

  // State register.
  always_ff @(posedge clk8 or negedge _reset) begin
    if (!_reset) state <= ST_IDLE;
    else         state <= state_n;
  end

  // Next-state logic: arbitration in IDLE, completion/abort in WAIT.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    sel     = tie_pick;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take0 || take1) begin
          start   = 1'b1;
          state_n = ST_WAIT;
          if (take0 && !take1)      sel = 1'b0;
          else if (take1 && !take0) sel = 1'b1;
          else                      sel = tie_pick;
        end
      end
      ST_WAIT: begin
        if (memReadAck) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end else if (expired) begin
          abort   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Address/grant capture at start; data, ack pulse and pointer at completion.
  always_ff @(posedge clk8 or negedge _reset) begin
    if (!_reset) begin
      memReadAddr <= '0;
      grant       <= 1'b0;
      rdData      <= 8'h00;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      tie_pick    <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (start) begin
        memReadAddr <= sel ? addr1 : addr0;
        grant       <= sel;
      end
      if (done || abort) begin
        rdData   <= done ? memReadData : 8'hFF;
        ack0     <= ~grant;
        ack1     <= grant;
        tie_pick <= ~grant;
      end
    end
  end

`ifdef FLOPPY_ARB_TIMEOUT_EN
  floppy_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk8    (clk8),
    ._reset  (_reset),
    .run     (busy),
    .expired (expired)
  );

  // Abort pulse, aligned with the ack pulse it accompanies.
  always_ff @(posedge clk8 or negedge _reset) begin
    if (!_reset) timeout <= 1'b0;
    else         timeout <= abort;
  end
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
